// File: rtl/two_digit_scan_ctrl.sv
// rtl/two_digit_scan_ctrl.sv - two-digit 7-segment scan controller with blanking and frame-synchronous value commit
//
// Scans a two-digit BCD value onto a shared seven_seg decoder. Each digit is
// preceded by a blank phase (enables off, nibble already presented) so the
// decoder settles before the digit lights. New values are held in a shadow
// register and committed only at the frame boundary.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   load        in   update request, sampled each rising edge
//   value_in    in   [7:4] tens BCD, [3:0] ones BCD
//   ready       out  high when no update is pending
//   digit_data  out  nibble for the seven_seg decoder
//   dig_en      out  digit enables, [1] tens, [0] ones
//   bcd_err     out  committed value holds a nibble > 9
//   frame_tick  out  one-cycle pulse at each frame boundary
module two_digit_scan_ctrl #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int LZB          = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] value_in,
   output logic       ready,
   output logic [3:0] digit_data,
   output logic [1:0] dig_en,
   output logic       bcd_err,
   output logic       frame_tick
);

   localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      BLANK_ONES = 2'd0,
      SHOW_ONES  = 2'd1,
      BLANK_TENS = 2'd2,
      SHOW_TENS  = 2'd3
   } state_t;

   state_t        state;
   state_t        nxt_state;
   logic [CW-1:0] cnt;
   logic [7:0]    disp;
   logic [7:0]    pend;
   logic          pend_v;

   logic          phase_end;
   logic          commit;
   logic [7:0]    nxt_disp;
   logic          nxt_pend_v;
   logic [3:0]    nxt_data;
   logic [1:0]    nxt_en;

   always_comb begin
      phase_end = (state == BLANK_ONES || state == BLANK_TENS) ? (cnt == BLANK_LAST)
                                                               : (cnt == SHOW_LAST);
      nxt_state = state;
      if (phase_end) begin
         case (state)
            BLANK_ONES: nxt_state = SHOW_ONES;
            SHOW_ONES:  nxt_state = BLANK_TENS;
            BLANK_TENS: nxt_state = SHOW_TENS;
            SHOW_TENS:  nxt_state = BLANK_ONES;
            default:    nxt_state = BLANK_ONES;
         endcase
      end

      commit = phase_end && (state == SHOW_TENS);

      // A load coinciding with the commit edge bypasses the shadow register.
      nxt_disp   = disp;
      nxt_pend_v = pend_v;
      if (commit) begin
         if (load)
            nxt_disp = value_in;
         else if (pend_v)
            nxt_disp = pend;
         nxt_pend_v = 1'b0;
      end else if (load) begin
         nxt_pend_v = 1'b1;
      end

      // Outputs are decoded from the next state so the registered pins line up
      // with the state register in the same cycle.
      nxt_data = nxt_disp[3:0];
      nxt_en   = 2'b00;
      case (nxt_state)
         BLANK_ONES: nxt_data = nxt_disp[3:0];
         SHOW_ONES: begin
            nxt_data = nxt_disp[3:0];
            nxt_en   = (nxt_disp[3:0] <= 4'd9) ? 2'b01 : 2'b00;
         end
         BLANK_TENS: nxt_data = nxt_disp[7:4];
         SHOW_TENS: begin
            nxt_data = nxt_disp[7:4];
            if (nxt_disp[7:4] <= 4'd9 && !((LZB != 0) && nxt_disp[7:4] == 4'd0))
               nxt_en = 2'b10;
         end
         default: nxt_en = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BLANK_ONES;
         cnt        <= '0;
         disp       <= 8'h00;
         pend       <= 8'h00;
         pend_v     <= 1'b0;
         ready      <= 1'b1;
         digit_data <= 4'h0;
         dig_en     <= 2'b00;
         bcd_err    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         state      <= nxt_state;
         cnt        <= phase_end ? '0 : cnt + CW'(1);
         disp       <= nxt_disp;
         if (load && !commit)
            pend <= value_in;
         pend_v     <= nxt_pend_v;
         ready      <= !nxt_pend_v;
         digit_data <= nxt_data;
         dig_en     <= nxt_en;
         // Follows the committed register, so it lags a commit by one cycle.
         bcd_err    <= (disp[7:4] > 4'd9) || (disp[3:0] > 4'd9);
         frame_tick <= commit;
      end
   end

endmodule

// File: tb/tb_two_digit_scan_ctrl.sv
// tb/tb_two_digit_scan_ctrl.sv - randomized self-checking bench for two_digit_scan_ctrl
module tb_two_digit_scan_ctrl;

   localparam int RD    = 4;
   localparam int BL    = 2;
   localparam int FRAME = 2 * (BL + RD);
   localparam logic [17:0] RESET_VEC = {2{9'b1_0000_00_0_0}};

   logic       clk;
   logic       rst;
   logic       load;
   logic [7:0] value_in;
   logic       ready_a, bcd_err_a, frame_tick_a;
   logic [3:0] digit_data_a;
   logic [1:0] dig_en_a;
   logic       ready_b, bcd_err_b, frame_tick_b;
   logic [3:0] digit_data_b;
   logic [1:0] dig_en_b;

   int vectors;
   int miscompares;

   // Reference model: position within the frame plus the value registers.
   int         pos;
   logic [7:0] m_disp;
   logic [7:0] m_pend;
   bit         m_pv;
   bit         m_err;
   bit         m_tick;

   two_digit_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZB(1)) dut (
      .clk(clk), .rst(rst), .load(load), .value_in(value_in),
      .ready(ready_a), .digit_data(digit_data_a), .dig_en(dig_en_a),
      .bcd_err(bcd_err_a), .frame_tick(frame_tick_a)
   );

   two_digit_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZB(0)) dut_nolzb (
      .clk(clk), .rst(rst), .load(load), .value_in(value_in),
      .ready(ready_b), .digit_data(digit_data_b), .dig_en(dig_en_b),
      .bcd_err(bcd_err_b), .frame_tick(frame_tick_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [17:0] obs();
      return {ready_a, digit_data_a, dig_en_a, bcd_err_a, frame_tick_a,
              ready_b, digit_data_b, dig_en_b, bcd_err_b, frame_tick_b};
   endfunction

   function automatic logic [8:0] model_out(input bit lzb);
      logic [3:0] lo;
      logic [3:0] hi;
      logic [3:0] d;
      logic [1:0] en;
      lo = m_disp[3:0];
      hi = m_disp[7:4];
      d  = (pos < 2 * BL + RD - BL) ? lo : hi;
      en = 2'b00;
      if (pos >= BL && pos < BL + RD && lo <= 9)
         en = 2'b01;
      if (pos >= 2 * BL + RD && hi <= 9 && !(lzb && hi == 0))
         en = 2'b10;
      return {!m_pv, d, en, m_err, m_tick};
   endfunction

   function automatic logic [17:0] expect_vec();
      return {model_out(1'b1), model_out(1'b0)};
   endfunction

   task automatic model_reset();
      pos    = 0;
      m_disp = 8'h00;
      m_pend = 8'h00;
      m_pv   = 0;
      m_err  = 0;
      m_tick = 0;
   endtask

   // One clock: drive inputs, advance the model across the edge, settle.
   task automatic step(input bit ld, input logic [7:0] v);
      bit commit;
      load     = ld;
      value_in = v;
      @(posedge clk);
      commit = (pos == FRAME - 1);
      m_err  = (m_disp[7:4] > 9) || (m_disp[3:0] > 9);
      if (commit) begin
         if (ld)
            m_disp = v;
         else if (m_pv)
            m_disp = m_pend;
         m_pv = 0;
      end else if (ld) begin
         m_pend = v;
         m_pv   = 1;
      end
      m_tick = commit;
      pos    = (pos + 1) % FRAME;
      #1;
      load = 1'b0;
   endtask

   task automatic advance_to(input int p);
      while (pos != p)
         step(1'b0, 8'h00);
   endtask

   function automatic logic [7:0] rand_bcd();
      return {4'($urandom_range(9)), 4'($urandom_range(9))};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      load = 1'b0;
      value_in = 8'h00;
      #17;
      vectors++;
      if (obs() !== RESET_VEC) begin
         miscompares++;
         $display("FAIL reset got=%h exp=%h", obs(), RESET_VEC);
      end
      #3 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 8'h00);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL idle cyc=%0d got=%h exp=%h", i + 1, obs(), expect_vec());
         end
      end
   endtask

   task automatic test_normal_load();
      logic [7:0] v;
      for (int n = 0; n < 4; n++) begin
         v = (n == 0) ? 8'h47 : rand_bcd();
         advance_to(BL + 1);
         step(1'b1, v);
         vectors++;
         if (ready_a !== 1'b0) begin
            miscompares++;
            $display("FAIL load_ready_fall val=%h got=%b exp=0", v, ready_a);
         end
         for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 8'h00);
            vectors++;
            if (obs() !== expect_vec()) begin
               miscompares++;
               $display("FAIL normal_load val=%h pos=%0d got=%h exp=%h", v, pos, obs(), expect_vec());
            end
         end
      end
   endtask

   task automatic test_overwrite();
      bit seen_old;
      advance_to(0);
      step(1'b1, 8'h66);
      advance_to(0);
      advance_to(1);
      step(1'b1, 8'h12);
      advance_to(BL + RD - 1);
      step(1'b1, 8'h35);
      seen_old = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 8'h00);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL overwrite pos=%0d got=%h exp=%h", pos, obs(), expect_vec());
         end
         if (dig_en_a != 2'b00 && (digit_data_a == 4'd1 || digit_data_a == 4'd2))
            seen_old = 1;
      end
      vectors++;
      if (seen_old) begin
         miscompares++;
         $display("FAIL overwrite_stale got=shown exp=never");
      end
   endtask

   task automatic test_coincident();
      advance_to(FRAME - 1);
      step(1'b1, 8'h88);
      vectors++;
      if (ready_a !== 1'b1 || frame_tick_a !== 1'b1) begin
         miscompares++;
         $display("FAIL coincident_commit got=ready%b/tick%b exp=ready1/tick1", ready_a, frame_tick_a);
      end
      for (int i = 0; i < FRAME; i++) begin
         step(1'b0, 8'h00);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL coincident pos=%0d got=%h exp=%h", pos, obs(), expect_vec());
         end
      end
   endtask

   task automatic test_invalid();
      logic [7:0] vals [2];
      logic       errs [2];
      vals[0] = 8'hA3; errs[0] = 1'b1;
      vals[1] = 8'h03; errs[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         advance_to(BL);
         step(1'b1, vals[n]);
         for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 8'h00);
            vectors++;
            if (obs() !== expect_vec()) begin
               miscompares++;
               $display("FAIL invalid val=%h pos=%0d got=%h exp=%h", vals[n], pos, obs(), expect_vec());
            end
         end
         vectors++;
         if (bcd_err_a !== errs[n]) begin
            miscompares++;
            $display("FAIL bcd_err val=%h got=%b exp=%b", vals[n], bcd_err_a, errs[n]);
         end
      end
   endtask

   task automatic test_leading_zero();
      advance_to(1);
      step(1'b1, 8'h05);
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 8'h00);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL leading_zero pos=%0d got=%h exp=%h", pos, obs(), expect_vec());
         end
      end
   endtask

   task automatic test_random();
      bit         ld;
      logic [7:0] v;
      for (int i = 0; i < 400; i++) begin
         ld = ($urandom_range(5) == 0);
         v  = ($urandom_range(3) == 0) ? 8'($urandom) : rand_bcd();
         step(ld, v);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL random i=%0d pos=%0d got=%h exp=%h", i, pos, obs(), expect_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      advance_to(1);
      step(1'b1, 8'h99);
      advance_to(2 * BL + RD + 1);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (obs() !== RESET_VEC) begin
         miscompares++;
         $display("FAIL mid_reset_async got=%h exp=%h", obs(), RESET_VEC);
      end
      #2 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(1'b0, 8'h00);
         vectors++;
         if (obs() !== expect_vec()) begin
            miscompares++;
            $display("FAIL mid_reset_after pos=%0d got=%h exp=%h", pos, obs(), expect_vec());
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_reset();
      test_reset();
      test_idle();
      test_normal_load();
      test_overwrite();
      test_coincident();
      test_invalid();
      test_leading_zero();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
